// File: rtl/tx_dcoffset_pkg.sv
// Shared definitions for the TX DC-offset correction blocks.
//   SAMPLE_W                : DAC sample width
//   ADDR_TX_DCOFF_I/_Q      : control-bus register addresses for the I and Q instances
//   OFFSET_LSB/MSB          : signed offset field inside the 32-bit write word
//   IMMEDIATE_BIT           : 1 = load the offset at once, 0 = slew toward it
//   dco_state_t             : offset-slew FSM state encoding
package tx_dcoffset_pkg;

    localparam int SAMPLE_W      = 16;

    localparam logic [6:0] ADDR_TX_DCOFF_I = 7'd20;
    localparam logic [6:0] ADDR_TX_DCOFF_Q = 7'd21;

    localparam int OFFSET_LSB    = 0;
    localparam int OFFSET_MSB    = 15;
    localparam int IMMEDIATE_BIT = 31;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } dco_state_t;

endpackage

// File: rtl/tx_dcoffset_add_sat16.sv
// add_sat16: combinational signed 16+16 adder with saturation to the
// 16-bit signed range. Shared by the TX correction blocks.
//   i_a, i_b : signed operands
//   o_sum    : saturated signed sum
module add_sat16
    import tx_dcoffset_pkg::*;
(
    input  logic [SAMPLE_W-1:0] i_a,
    input  logic [SAMPLE_W-1:0] i_b,
    output logic [SAMPLE_W-1:0] o_sum
);

    logic [SAMPLE_W:0] w_sum;

    assign w_sum = {i_a[SAMPLE_W-1], i_a} + {i_b[SAMPLE_W-1], i_b};

    // The two top bits of the sign-extended sum disagree exactly on overflow;
    // the extra bit then carries the true sign.
    always_comb begin
        o_sum = w_sum[SAMPLE_W-1:0];
        if (w_sum[SAMPLE_W] != w_sum[SAMPLE_W-1]) begin
            o_sum = w_sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                    : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/tx_dcoffset.sv
// tx_dcoffset: adds a host-programmed signed DC offset to one DAC sample
// stream, with saturation. Offset changes are slewed by RAMP_STEP per
// enabled sample, or loaded immediately when the write requests it.
//   clock, reset          : system clock, synchronous active-low reset
//   enable                : 0 = bypass samples and freeze the slew
//   strobe_in, dac_in     : input sample and its valid
//   dac_out, strobe_out   : corrected sample (registered) and its valid
//   serial_addr/data/strobe : control-bus register write
//   ramp_busy             : applied offset has not yet reached the target
//
// state | meaning
// IDLE  | applied offset equals target, held
// RAMP  | applied offset steps toward target on each enabled sample
module tx_dcoffset
    import tx_dcoffset_pkg::*;
#(
    parameter logic [6:0] MYADDR    = 7'd0,
    parameter int         RAMP_STEP = 16
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                strobe_in,
    input  logic [SAMPLE_W-1:0] dac_in,
    output logic [SAMPLE_W-1:0] dac_out,
    output logic                strobe_out,
    input  logic [6:0]          serial_addr,
    input  logic [31:0]         serial_data,
    input  logic                serial_strobe,
    output logic                ramp_busy
);

    localparam logic [SAMPLE_W-1:0] STEP16 = SAMPLE_W'(RAMP_STEP);
    localparam logic [SAMPLE_W:0]   STEP17 = (SAMPLE_W+1)'(RAMP_STEP);

    dco_state_t          r_state;
    dco_state_t          w_next_state;
    logic [SAMPLE_W-1:0] r_cur_off;
    logic [SAMPLE_W-1:0] r_target;
    logic [SAMPLE_W-1:0] w_next_cur;
    logic [SAMPLE_W-1:0] w_next_tgt;
    logic [SAMPLE_W-1:0] r_dac_out;
    logic                r_strobe_out;
    logic                r_ramp_busy;

    logic                w_wr;
    logic                w_wr_imm;
    logic [SAMPLE_W-1:0] w_wr_val;
    logic [SAMPLE_W:0]   w_diff;
    logic [SAMPLE_W:0]   w_abs_diff;
    logic [SAMPLE_W-1:0] w_sum_sat;

    assign w_wr     = serial_strobe && (serial_addr == MYADDR);
    assign w_wr_imm = serial_data[IMMEDIATE_BIT];
    assign w_wr_val = serial_data[OFFSET_MSB:OFFSET_LSB];

    // One extra bit so target - cur_off cannot overflow.
    assign w_diff     = {r_target[SAMPLE_W-1], r_target} - {r_cur_off[SAMPLE_W-1], r_cur_off};
    assign w_abs_diff = w_diff[SAMPLE_W] ? (~w_diff + 1'b1) : w_diff;

    add_sat16 u_add_sat16 (
        .i_a   (dac_in),
        .i_b   (r_cur_off),
        .o_sum (w_sum_sat)
    );

    // A register write takes precedence over a slew step on the same edge.
    always_comb begin
        w_next_state = r_state;
        w_next_cur   = r_cur_off;
        w_next_tgt   = r_target;
        if (w_wr) begin
            w_next_tgt = w_wr_val;
            if (w_wr_imm) begin
                w_next_cur   = w_wr_val;
                w_next_state = ST_IDLE;
            end else begin
                w_next_state = (w_wr_val != r_cur_off) ? ST_RAMP : ST_IDLE;
            end
        end else if ((r_state == ST_RAMP) && strobe_in && enable) begin
            if (w_abs_diff <= STEP17) begin
                w_next_cur   = r_target;
                w_next_state = ST_IDLE;
            end else if (w_diff[SAMPLE_W]) begin
                w_next_cur = r_cur_off - STEP16;
            end else begin
                w_next_cur = r_cur_off + STEP16;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cur_off    <= '0;
            r_target     <= '0;
            r_ramp_busy  <= 1'b0;
            r_dac_out    <= '0;
            r_strobe_out <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cur_off    <= w_next_cur;
            r_target     <= w_next_tgt;
            r_ramp_busy  <= (w_next_state == ST_RAMP);
            r_strobe_out <= strobe_in;
            if (strobe_in) begin
                r_dac_out <= enable ? w_sum_sat : dac_in;
            end
        end
    end

    assign dac_out    = r_dac_out;
    assign strobe_out = r_strobe_out;
    assign ramp_busy  = r_ramp_busy;

endmodule

// File: tb/tb_tx_dcoffset.sv
module tb_tx_dcoffset;
    import tx_dcoffset_pkg::*;

    localparam logic [6:0] ADDR = ADDR_TX_DCOFF_I;
    localparam int         STEP = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        strobe_in = 1'b0;
    logic [15:0] dac_in = '0;
    logic [15:0] dac_out;
    logic        strobe_out;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic        ramp_busy;

    tx_dcoffset #(.MYADDR(ADDR), .RAMP_STEP(STEP)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .strobe_in     (strobe_in),
        .dac_in        (dac_in),
        .dac_out       (dac_out),
        .strobe_out    (strobe_out),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .ramp_busy     (ramp_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic so;
        logic busy;
        logic in_reset;
    } ctrl_t;

    ctrl_t       q_ctrl[$];
    logic [15:0] q_samp[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: applied offset and target as plain integers.
    int m_cur = 0;
    int m_tgt = 0;

    function automatic int clip16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic en, input logic stb,
                         input logic [15:0] din, input logic wr,
                         input logic [6:0] addr, input logic [31:0] data);
        ctrl_t c;
        int    v;
        int    d;
        int    o;
        @(negedge clock);
        reset = rst; enable = en; strobe_in = stb; dac_in = din;
        serial_strobe = wr; serial_addr = addr; serial_data = data;
        if (!rst) begin
            m_cur = 0; m_tgt = 0;
            c.so = 1'b0; c.busy = 1'b0; c.in_reset = 1'b1;
        end else begin
            if (stb) begin
                o = en ? clip16(int'($signed(din)) + m_cur) : int'($signed(din));
                q_samp.push_back(16'(o));
            end
            if (wr && addr == ADDR) begin
                v = int'($signed(data[15:0]));
                m_tgt = v;
                if (data[31]) m_cur = v;
            end else if (stb && en && m_cur != m_tgt) begin
                d = m_tgt - m_cur;
                if (d <= STEP && d >= -STEP) m_cur = m_tgt;
                else m_cur = m_cur + ((d > 0) ? STEP : -STEP);
            end
            c.so = stb; c.busy = (m_cur != m_tgt); c.in_reset = 1'b0;
        end
        q_ctrl.push_back(c);
    endtask

    task automatic samp(input logic [15:0] din, input logic en = 1'b1);
        drive(1'b1, en, 1'b1, din, 1'b0, 7'd0, 32'd0);
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 7'd0, 32'd0);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [31:0] data);
        drive(1'b1, 1'b1, 1'b0, 16'd0, 1'b1, addr, data);
    endtask

    // Monitor: samples 1 time unit after each active edge.
    initial begin
        ctrl_t       c;
        logic [15:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (q_ctrl.size() > 0) begin
                c = q_ctrl.pop_front();
                n_vec++;
                if (strobe_out !== c.so || ramp_busy !== c.busy) begin
                    n_err++;
                    $display("FAIL ctrl t=%0t strobe_out=%b busy=%b expected strobe_out=%b busy=%b",
                             $time, strobe_out, ramp_busy, c.so, c.busy);
                end
                if (c.in_reset) begin
                    n_vec++;
                    if (dac_out !== 16'd0) begin
                        n_err++;
                        $display("FAIL reset_dac t=%0t got %0d expected 0", $time, $signed(dac_out));
                    end
                end
            end
            if (strobe_out === 1'b1) begin
                n_vec++;
                if (q_samp.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_sample t=%0t got %0d with no expected sample", $time, $signed(dac_out));
                end else begin
                    e = q_samp.pop_front();
                    if (dac_out !== e) begin
                        n_err++;
                        $display("FAIL dac_out t=%0t got %0d expected %0d", $time, $signed(dac_out), $signed(e));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        // Reset held while strobes and writes are driven.
        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 1'b1, 16'd777, 1'b1, ADDR, 32'h8000_0100);
        samp(16'd1234);
        idle();
        // Immediate load.
        wr(ADDR, 32'h8000_0100);
        samp(16'd1000);
        idle();
        // Ramp 0 -> 40 with idle cycles between strobes.
        wr(ADDR, 32'h8000_0000);
        wr(ADDR, 32'h0000_0028);
        for (int i = 0; i < 4; i++) begin
            idle(); idle();
            samp(16'd0);
        end
        // Saturation both sides.
        wr(ADDR, 32'h8000_7FFF);
        samp(16'd100);
        wr(ADDR, 32'h8000_8000);
        samp(16'hFFFF);
        // Foreign address, retarget, enable gating.
        wr(ADDR, 32'h8000_0000);
        wr(ADDR + 7'd1, 32'h8000_1000);
        samp(16'd7);
        wr(ADDR, 32'h0000_0040);
        samp(16'd0);
        wr(ADDR, 32'h0000_0000);
        samp(16'd0);
        samp(16'd0);
        wr(ADDR, 32'h0000_01F4);
        for (int i = 0; i < 3; i++) samp(16'd300, 1'b0);
        samp(16'd300);
        // Write and step on the same edge: the write wins.
        drive(1'b1, 1'b1, 1'b1, 16'd10, 1'b1, ADDR, 32'h0000_0100);
        samp(16'd10);
        // Reset mid-ramp.
        wr(ADDR, 32'h8000_0000);
        wr(ADDR, 32'h0000_03E8);
        for (int i = 0; i < 3; i++) samp(16'd0);
        drive(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 7'd0, 32'd0);
        samp(16'd5);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            if ($urandom_range(3) == 0) w[15:0] = 16'($urandom_range(0, 200)) - 16'd100;
            drive(($urandom_range(99) != 0),
                  ($urandom_range(7) != 0),
                  1'($urandom_range(1)),
                  ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 400)),
                  ($urandom_range(9) == 0),
                  ($urandom_range(2) == 0) ? ADDR + 7'd1 : ADDR,
                  w);
        end
        idle();
        idle();
        @(posedge clock);
        #2;
        n_vec++;
        if (q_samp.size() != 0 || q_ctrl.size() != 0) begin
            n_err++;
            $display("FAIL drain samples_left=%0d ctrl_left=%0d expected 0 and 0", q_samp.size(), q_ctrl.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_dcoffset.md
Name: tx_dcoffset

Overview:
- Transmit-path DC-offset correction for one 16-bit DAC sample stream (I or Q); instantiate once per DAC channel, between the TX interpolator output and the DAC pins.
- Adds a host-programmed signed offset to every outgoing sample, with saturation.
- The offset is loaded over the serial control bus.
- Offset changes are normally slewed in fixed steps, one step per transmitted sample, to avoid spectral splatter; an immediate mode is also available.

Parameters:
- MYADDR, 0: serial-bus register address of this block.
- RAMP_STEP, 16: maximum change of the applied offset per enabled sample strobe, in LSBs (1..16384).

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- enable  in  1  block enable; 0 = bypass and ramp frozen.
- strobe_in  in  1  dac_in valid this cycle.
- dac_in  in  16  signed input sample.
- dac_out  out  16  signed corrected sample, registered.
- strobe_out  out  1  dac_out valid; strobe_in delayed one cycle.
- serial_addr  in  7  control-bus register address.
- serial_data  in  32  control-bus data.
- serial_strobe  in  1  control-bus write strobe.
- ramp_busy  out  1  1 while the applied offset differs from the target.

Behaviour:
- Reset (reset==0 at a clock edge):
  - cur_off=0, target=0, FSM=IDLE.
  - dac_out=0, strobe_out=0, ramp_busy=0.
  - Reset takes priority over a simultaneous serial write or sample strobe.
- Register write: fires when serial_strobe==1 and serial_addr==MYADDR. Field layout:
  - serial_data[15:0] is the signed target offset.
  - serial_data[31] is the immediate flag; bits 30:16 are ignored.
  - A write with any other address has no effect.
- Immediate write (bit31=1): target and cur_off both take the new value at that edge; FSM=IDLE.
- Ramped write (bit31=0): only target is updated.
  - FSM=RAMP if the new target differs from cur_off; otherwise FSM=IDLE.
  - A write during RAMP retargets; the ramp continues from the current cur_off.
- FSM IDLE: cur_off is held.
- FSM RAMP: on each edge with strobe_in & enable:
  - Compute diff = target - cur_off in 17-bit signed, so no overflow.
  - If |diff| <= RAMP_STEP, cur_off=target and FSM->IDLE.
  - Otherwise cur_off moves by +RAMP_STEP or -RAMP_STEP toward target.
  - No step occurs on edges without a strobe, or when enable==0.
- Simultaneous ramp step and serial write: the write wins. cur_off is not stepped that edge, except that an immediate write loads cur_off directly.
- ramp_busy is registered and equals (FSM==RAMP). It rises the edge after a ramped write and falls on the edge cur_off reaches target.
- Datapath, latency 1 cycle: on every edge,
  - strobe_out <= strobe_in.
  - If strobe_in: dac_out <= enable ? sat16(dac_in + cur_off) : dac_in. Otherwise dac_out holds.
  - cur_off used is the value before any update on the same edge.
- Saturation: the 17-bit sum is clipped to the range [-32768, 32767].
- A change of enable takes effect on the next strobed sample.

Decomposition:
- Shared package holds:
  - SAMPLE_W=16.
  - The serial address constants for the TX DC-offset registers (I and Q).
  - Field positions OFFSET_LSB=0, OFFSET_MSB=15, IMMEDIATE_BIT=31.
  - The FSM state encoding IDLE/RAMP.
- One sub-module: add_sat16, a combinational signed 16+16 adder producing a 16-bit saturated result. It is reusable by other TX correction blocks.

Test Plan:
- Reset: hold reset=0 while driving strobes and writes -> dac_out=0, strobe_out=0, ramp_busy=0. After release, dac_in=1234 strobed -> dac_out=1234 one cycle later.
- Immediate: write 0x8000_0100 to MYADDR, then strobe dac_in=1000 -> dac_out=1256 next cycle, with ramp_busy never asserted.
- Ramp: RAMP_STEP=16, offset 0, ramped write 0x0000_0028, then strobe dac_in=0 four times -> dac_out 0,16,32,40. ramp_busy falls at the edge of the 3rd strobe; idle cycles between strobes do not advance the ramp.
- Saturation, high side: immediate offset 32767, dac_in=100 -> dac_out=32767.
- Saturation, low side: immediate offset -32768 (0x8000_8000), dac_in=-1 -> dac_out=-32768.
- Address, retarget, enable:
  - A write to MYADDR+1 changes nothing.
  - A ramped write of 64, then after one step (16) a ramped write of 0 -> next outputs use offsets 16, 0.
  - With enable=0, dac_out=dac_in and the ramp does not advance.
- Reset mid-ramp: ramp toward 1000, assert reset at step 3 -> cur_off=0 and ramp_busy=0. The next strobed dac_in=5 gives dac_out=5.
